atm_tx_port: RTL
================

ATM_TX_PORT -- requirements
Module: atm_tx_port

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels (1-8).
REQ-002 SHALL have parameter DATA_W, default 8, Tx word width in bits (8 or 16).
REQ-003 SHALL have parameter CELL_WORDS, default 53, words per ATM cell.
REQ-004 SHALL have parameter FIFO_DEPTH, default 128, words per channel FIFO (power of 2, >= CELL_WORDS).
REQ-005 SHALL use one clock, clk; reset rst is asynchronous, active-high.
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port wr_valid, input, NUM_CH, per-channel word write strobe.
REQ-009 SHALL have port wr_data, input, NUM_CH*DATA_W, per-channel write words; channel i is slice i.
REQ-010 SHALL have port wr_ready, output, NUM_CH, per-channel FIFO not full.
REQ-011 SHALL have port tx_data, output, DATA_W, cell word to the PHY.
REQ-012 SHALL have port tx_soc, output, 1, high with the first word of a cell.
REQ-013 SHALL have port tx_en, output, 1, high when tx_data holds a valid word.
REQ-014 SHALL have port tx_clav, input, 1, PHY cell-available or can-accept flag.
REQ-015 SHALL have port cell_sent, output, 1, one-cycle pulse after the last word of a cell.
REQ-016 SHALL have port cur_ch, output, $clog2(NUM_CH) (minimum 1), channel currently sending.

Function
REQ-017 SHALL accept a write on channel i when wr_valid[i] and wr_ready[i] are both high; writes while full are dropped.
REQ-018 SHALL count complete cells per channel; a channel is eligible when it holds at least one complete cell (CELL_WORDS words).
REQ-019 SHALL implement FSM IDLE -> ARB -> SEND -> IDLE.
- IDLE -> ARB when tx_clav=1 and any channel is eligible.
- ARB: one cycle; round-robin grant starting from the channel after the last one granted.
- SEND -> IDLE after the final word.
REQ-020 SHALL, in SEND, drive one word per cycle while tx_clav=1; tx_soc=1 only on word 0.
REQ-021 SHALL, if tx_clav=0 mid-cell, hold tx_en=0 and keep tx_data and the word index frozen; sending resumes at the same index when tx_clav returns to 1.
REQ-022 SHALL register tx_data, tx_soc and tx_en; first word appears 1 cycle after ARB.
REQ-023 SHALL pulse cell_sent the cycle after the last word, and decrement that channel's cell count in the same cycle.
REQ-024 SHALL allow a simultaneous write and read on the same channel; full/empty flags and cell counts stay exact, and pointers wrap modulo FIFO_DEPTH.
REQ-025 SHALL never grant a channel holding only a partial cell.

Reset
REQ-026 SHALL, on rst, clear all FIFO pointers, cell counts and the word index.
REQ-027 SHALL, on rst, return the FSM to IDLE and reset the round-robin pointer to channel NUM_CH-1, so channel 0 wins first.
REQ-028 SHALL reset outputs as: tx_en=0, tx_soc=0, tx_data=0, cell_sent=0, cur_ch=0, wr_ready=all-1.
REQ-029 SHALL, on rst during SEND, abort the cell immediately and discard the partial cell.

Configuration
REQ-030 SHALL, with ATM_TX_HEC_EN defined, replace word index 4 with the HEC.
- HEC = CRC-8 (x^8+x^2+x+1, init 0) over words 0-3, XOR 0x55.
- The stored word 4 is discarded.
- DATA_W must be 8, otherwise elaboration fails.
REQ-031 SHALL, without ATM_TX_HEC_EN, transmit all stored words unmodified.

Structure
REQ-032 SHALL place the FSM state enum, the HEC polynomial constant (0x07) and the coset constant (0x55) in package atm_tx_pkg.
REQ-033 SHALL instantiate sub-module atm_cell_fifo once per channel (storage, pointers, cell count).

Verification
REQ-034 SHALL test reset: rst mid-cell on ch0 -> next cycle tx_en=0, FSM IDLE, wr_ready=all-1.
REQ-035 SHALL test single cell: 53 words 0x00..0x34 to ch2, tx_clav=1 -> tx_soc=1 with 0x00, 53 contiguous tx_en cycles, cell_sent pulse, cur_ch=2.
REQ-036 SHALL test round-robin: one cell each on ch0, ch1, ch3 -> send order 0,1,3; two more cells on ch0 and ch1 -> order 0,1.
REQ-037 SHALL test backpressure: tx_clav=0 for 5 cycles after word 10 -> tx_en=0 for 5 cycles, then word 11 follows with no word lost or repeated.
REQ-038 SHALL test full/wrap: write 130 words to ch1 with FIFO_DEPTH=128 -> wr_ready=0 after 128 and 2 words dropped; drain 2 cells and refill -> wrapped data correct.
REQ-039 SHALL test HEC (ATM_TX_HEC_EN): header 00 00 00 00 xx -> word 4 sent as 0x55; header 00 00 00 01 -> 0x52.

Source files
------------

// File: rtl/atm_tx_pkg.sv
// Shared definitions for the ATM cell transmit port: FSM states and the
// HEC (CRC-8) constants and helper used when ATM_TX_HEC_EN is defined.
package atm_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_SEND = 2'd2
    } tx_state_t;

    // CRC-8 generator x^8 + x^2 + x + 1 (the x^8 term is implicit)
    localparam logic [7:0] HEC_POLY  = 8'h07;
    // Coset added to the CRC before it goes on the line
    localparam logic [7:0] HEC_COSET = 8'h55;

    // Fold one byte into a running MSB-first CRC-8
    function automatic logic [7:0] hec_crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ HEC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/atm_cell_fifo.sv
// Per-channel word FIFO that also tracks how many complete cells it holds.
// A cell is counted when its last word is written and released when the
// transmitter reports the cell as sent.
module atm_cell_fifo
    import atm_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CELL_WORDS = 53,
    parameter int FIFO_DEPTH = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_cell_done,
    output logic              o_cell_avail
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (CELL_WORDS > 1) ? $clog2(CELL_WORDS) : 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [AW:0]       r_cells;
    logic [PW-1:0]     r_part;
    logic              w_full;
    logic              w_wr;
    logic              w_cell_in;

    assign w_full       = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_wr         = i_wr_valid && !w_full;
    assign w_cell_in    = w_wr && (r_part == PW'(CELL_WORDS - 1));
    assign o_wr_ready   = !w_full;
    assign o_rd_data    = r_mem[r_rd_ptr];
    assign o_cell_avail = (r_cells != (AW+1)'(0));

    // Word storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_part   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_part   <= w_cell_in ? PW'(0) : (r_part + PW'(1));
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Word and cell occupancy, exact under simultaneous increment/decrement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_cells <= '0;
        end else begin
            case ({w_wr, i_rd_en})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            case ({w_cell_in, i_cell_done})
                2'b10:   r_cells <= r_cells + (AW+1)'(1);
                2'b01:   r_cells <= r_cells - (AW+1)'(1);
                default: r_cells <= r_cells;
            endcase
        end
    end

endmodule

// File: rtl/atm_tx_port.sv
// Multi-channel ATM cell transmitter: per-channel cell FIFOs, round-robin
// cell arbitration and a word-serial PHY interface with tx_clav flow control.
// Optional: define ATM_TX_HEC_EN to replace word 4 of each cell by the HEC.
module atm_tx_port
    import atm_tx_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 8,
    parameter int CELL_WORDS = 53,
    parameter int FIFO_DEPTH = 128,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        wr_valid,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    output logic [NUM_CH-1:0]        wr_ready,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_soc,
    output logic                     tx_en,
    input  logic                     tx_clav,
    output logic                     cell_sent,
    output logic [CH_W-1:0]          cur_ch
);
    localparam int IDX_W = $clog2(CELL_WORDS + 1);

    tx_state_t         r_state;
    tx_state_t         w_next;
    logic [NUM_CH-1:0] w_cell_avail;
    logic [NUM_CH-1:0] w_rd_en;
    logic [NUM_CH-1:0] w_cell_done;
    logic [DATA_W-1:0] w_rd_data [NUM_CH];
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_tx_word;
    logic [CH_W-1:0]   w_grant;
    logic [CH_W-1:0]   w_rd_ch;
    logic [CH_W-1:0]   r_last;
    logic [CH_W-1:0]   r_cur_ch;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_soc;
    logic              r_tx_en;
    logic              r_cell_sent;
    logic              w_any;
    logic              w_issue;
    logic              w_done;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        atm_cell_fifo #(
            .DATA_W     (DATA_W),
            .CELL_WORDS (CELL_WORDS),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk          (clk),
            .rst          (rst),
            .i_wr_valid   (wr_valid[g]),
            .i_wr_data    (wr_data[g*DATA_W +: DATA_W]),
            .o_wr_ready   (wr_ready[g]),
            .i_rd_en      (w_rd_en[g]),
            .o_rd_data    (w_rd_data[g]),
            .i_cell_done  (w_cell_done[g]),
            .o_cell_avail (w_cell_avail[g])
        );
        assign w_rd_en[g]     = w_issue && (w_rd_ch == CH_W'(g));
        assign w_cell_done[g] = w_done && (r_cur_ch == CH_W'(g));
    end

    assign w_rd_word = w_rd_data[w_rd_ch];

    // Round-robin search starting at the channel after the last grant
    always_comb begin
        int c;
        c       = 0;
        w_grant = r_last;
        w_any   = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = (int'(r_last) + k) % NUM_CH;
            if (!w_any && w_cell_avail[c]) begin
                w_any   = 1'b1;
                w_grant = CH_W'(c);
            end else begin
                w_any   = w_any;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; SEND ends once every word has been issued
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (tx_clav && w_any) w_next = ST_ARB;
                else                  w_next = ST_IDLE;
            end
            ST_ARB:  w_next = ST_SEND;
            ST_SEND: begin
                if (r_idx == IDX_W'(CELL_WORDS)) w_next = ST_IDLE;
                else                             w_next = ST_SEND;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM outputs: word 0 already leaves in ARB so it appears right after it
    always_comb begin
        w_issue = 1'b0;
        w_done  = 1'b0;
        w_rd_ch = r_cur_ch;
        case (r_state)
            ST_ARB: begin
                w_issue = tx_clav;
                w_rd_ch = w_grant;
            end
            ST_SEND: begin
                if (r_idx == IDX_W'(CELL_WORDS)) w_done  = 1'b1;
                else                             w_issue = tx_clav;
            end
            default: begin
                w_issue = 1'b0;
            end
        endcase
    end

`ifdef ATM_TX_HEC_EN
    logic [7:0] r_crc;

    if (DATA_W != 8) begin : g_hec_width_check
        $error("atm_tx_port: ATM_TX_HEC_EN requires DATA_W == 8");
    end

    // Running CRC over header words 0..3, restarted at word 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= 8'h00;
        end else if (w_issue) begin
            r_crc <= hec_crc8_byte((r_idx == IDX_W'(0)) ? 8'h00 : r_crc, w_rd_word);
        end
    end

    // Word 4 is replaced by the HEC; the stored word is read and dropped
    always_comb begin
        if (r_idx == IDX_W'(4)) w_tx_word = r_crc ^ HEC_COSET;
        else                    w_tx_word = w_rd_word;
    end
`else
    // Stored words pass through unmodified
    always_comb begin
        w_tx_word = w_rd_word;
    end
`endif

    // Registered PHY outputs, word index and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_data   <= '0;
            r_tx_soc    <= 1'b0;
            r_tx_en     <= 1'b0;
            r_cell_sent <= 1'b0;
            r_idx       <= '0;
            r_cur_ch    <= '0;
            r_last      <= CH_W'(NUM_CH - 1);
        end else begin
            r_cell_sent <= w_done;
            if (w_issue) begin
                r_tx_data <= w_tx_word;
                r_tx_en   <= 1'b1;
                r_tx_soc  <= (r_idx == IDX_W'(0));
                r_idx     <= r_idx + IDX_W'(1);
            end else begin
                r_tx_en   <= 1'b0;
                r_tx_soc  <= 1'b0;
                r_idx     <= w_done ? IDX_W'(0) : r_idx;
            end
            if (r_state == ST_ARB) begin
                r_cur_ch <= w_grant;
                r_last   <= w_grant;
            end
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_soc    = r_tx_soc;
    assign tx_en     = r_tx_en;
    assign cell_sent = r_cell_sent;
    assign cur_ch    = r_cur_ch;

endmodule
